// File: rtl/clk_rst_sequencer_pkg.sv
// Shared board package for the clock/reset sequencer.
// Holds the state encoding, the default timing parameters and the output decode.
package clk_rst_sequencer_pkg;

  localparam int unsigned LOCK_STABLE_CYCLES_DEFAULT = 1024;
  localparam int unsigned STAGE_GAP_CYCLES_DEFAULT   = 16;
  localparam int          CNT_W                      = 16;
  localparam int          LOSS_W                     = 8;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_STABLE  = 3'd1,
    ST_SOFT    = 3'd2,
    ST_REL_MEM = 3'd3,
    ST_REL_CPU = 3'd4,
    ST_REL_LCD = 3'd5,
    ST_RUN     = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic rst_mem;
    logic rst_cpu;
    logic rst_lcd;
    logic ready;
  } seq_out_t;

  localparam seq_out_t OUT_ALL_RESET = '{rst_mem: 1'b1, rst_cpu: 1'b1, rst_lcd: 1'b1, ready: 1'b0};

  // Stages release in order mem -> cpu -> lcd; anything unexpected holds everything in reset.
  function automatic seq_out_t decode_outputs(input seq_state_e s);
    seq_out_t o;
    o = OUT_ALL_RESET;
    case (s)
      ST_REL_MEM: o = '{rst_mem: 1'b0, rst_cpu: 1'b1, rst_lcd: 1'b1, ready: 1'b0};
      ST_REL_CPU: o = '{rst_mem: 1'b0, rst_cpu: 1'b0, rst_lcd: 1'b1, ready: 1'b0};
      ST_REL_LCD: o = '{rst_mem: 1'b0, rst_cpu: 1'b0, rst_lcd: 1'b0, ready: 1'b0};
      ST_RUN:     o = '{rst_mem: 1'b0, rst_cpu: 1'b0, rst_lcd: 1'b0, ready: 1'b1};
      default:    o = OUT_ALL_RESET;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/clk_rst_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
// Reusable for any board input that is asynchronous to clk.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Board reset sequencer: waits for a stable PLL lock, then releases the
// memory, CPU and LCD resets in turn, restarting on lock loss or soft reset.
module clk_rst_sequencer
  import clk_rst_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEFAULT,
  parameter int unsigned STAGE_GAP_CYCLES   = STAGE_GAP_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       soft_rst,
  output logic       rst_mem,
  output logic       rst_cpu,
  output logic       rst_lcd,
  output logic       ready,
  output logic [7:0] loss_cnt
);

  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = '1;

  logic              lock_sync;
  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [LOSS_W-1:0] loss_q;
  logic [LOSS_W-1:0] loss_d;
  seq_out_t          out_q;
  seq_out_t          out_d;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (pll_lock),
    .q  (lock_sync)
  );

  // Priority: lock loss beats soft reset, which beats the normal stage progression.
  // Loss from STABLE is not counted since the PLL was never considered locked.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    if (state_q != ST_HOLD && !lock_sync) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      if (state_q != ST_STABLE && loss_q != LOSS_MAX) begin
        loss_d = loss_q + LOSS_W'(1);
      end
    end else if (soft_rst && (state_q inside {ST_REL_MEM, ST_REL_CPU, ST_REL_LCD, ST_RUN})) begin
      state_d = ST_SOFT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (lock_sync) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end
        end
        ST_STABLE: begin
          if (cnt_q == LOCK_LAST) begin
            state_d = ST_REL_MEM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SOFT: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_REL_MEM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REL_MEM: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_REL_CPU;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REL_CPU: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_REL_LCD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REL_LCD: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
    out_d = decode_outputs(state_d);
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      loss_q  <= '0;
      out_q   <= OUT_ALL_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      out_q   <= out_d;
    end
  end

  assign rst_mem  = out_q.rst_mem;
  assign rst_cpu  = out_q.rst_cpu;
  assign rst_lcd  = out_q.rst_lcd;
  assign ready    = out_q.ready;
  assign loss_cnt = loss_q;

endmodule
